// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: buttons -> start/pause and lap/clear FSM,
// drives count tick, sync clear and lap hold to the BCD digit chain.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   btn_start  raw start/pause button level (async to clk)
//   btn_lap    raw lap/clear button level (async to clk)
//   tick       one-cycle count enable to least-significant digit
//   clr        one-cycle synchronous clear to all digits
//   lap        high while digits hold their displayed value
//   state      FSM state: IDLE=00 RUN=01 PAUSE=10 LAP=11
module stopwatch_ctrl #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_lap,
    output logic       tick,
    output logic       clr,
    output logic       lap,
    output logic [1:0] state
);

    localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_LAP   = 2'b11
    } state_t;

    state_t cur;
    state_t nxt;

    // bit0 = s1, bit1 = s2, bit2 = s3
    logic [2:0] st_sync;
    logic [2:0] lp_sync;
    logic       start_p;
    logic       lap_p;

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;
    logic         tick_nxt;
    logic         clr_evt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_sync <= '0;
            lp_sync <= '0;
        end else begin
            st_sync <= {st_sync[1:0], btn_start};
            lp_sync <= {lp_sync[1:0], btn_lap};
        end
    end

    assign start_p = st_sync[1] & ~st_sync[2];
    assign lap_p   = lp_sync[1] & ~lp_sync[2];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur <= S_IDLE;
        end else begin
            cur <= nxt;
        end
    end

    // Next-state logic; start press wins over a simultaneous lap press
    always_comb begin
        nxt     = cur;
        clr_evt = 1'b0;
        case (cur)
            S_IDLE: begin
                if (start_p) begin
                    nxt = S_RUN;
                end else if (lap_p) begin
                    clr_evt = 1'b1;
                end
            end
            S_RUN: begin
                if (start_p) begin
                    nxt = S_PAUSE;
                end else if (lap_p) begin
                    nxt = S_LAP;
                end
            end
            S_LAP: begin
                if (start_p) begin
                    nxt = S_PAUSE;
                end else if (lap_p) begin
                    nxt = S_RUN;
                end
            end
            S_PAUSE: begin
                if (start_p) begin
                    nxt = S_RUN;
                end else if (lap_p) begin
                    nxt     = S_IDLE;
                    clr_evt = 1'b1;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    // Prescaler follows the current state, so a wrap on the edge that
    // leaves RUN still produces its tick.
    always_comb begin
        cnt_nxt  = cnt;
        tick_nxt = 1'b0;
        case (cur)
            S_RUN, S_LAP: begin
                if (cnt == LAST) begin
                    cnt_nxt  = '0;
                    tick_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_PAUSE: cnt_nxt = cnt;
            default: cnt_nxt = '0;
        endcase
        if (clr_evt) begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            tick <= 1'b0;
            clr  <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            tick <= tick_nxt;
            clr  <= clr_evt;
        end
    end

    // Outputs decoded from the state register only
    always_comb begin
        state = cur;
        lap   = (cur == S_LAP);
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed testbench for stopwatch_ctrl with TICK_DIV=4.
// Observed vector is {state, lap, tick, clr}.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_lap = 1'b0;
    logic       tick;
    logic       clr;
    logic       lap;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    stopwatch_ctrl #(.TICK_DIV(4)) dut (
        .clk(clk),
        .reset(reset),
        .btn_start(btn_start),
        .btn_lap(btn_lap),
        .tick(tick),
        .clr(clr),
        .lap(lap),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        if ({state, lap, tick, clr} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_async got %b exp %b", {state, lap, tick, clr}, 5'b00000);
        end
        checks++;
        step();
        step();
        if ({state, lap, tick, clr} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_held got %b exp %b", {state, lap, tick, clr}, 5'b00000);
        end
        checks++;
        #3 reset = 1'b1;
        step();
        if ({state, lap, tick, clr} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_release got %b exp %b", {state, lap, tick, clr}, 5'b00000);
        end
        checks++;
    endtask

    task automatic test_run();
        logic [4:0] exp_v;
        btn_start = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            exp_v = (i == 3) ? 5'b01000 : 5'b00000;
            if ({state, lap, tick, clr} !== exp_v) begin
                errors++;
                $display("FAIL run_latency[%0d] got %b exp %b", i, {state, lap, tick, clr}, exp_v);
            end
            checks++;
        end
        btn_start = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            step();
            exp_v = (i % 4 == 0) ? 5'b01010 : 5'b01000;
            if ({state, lap, tick, clr} !== exp_v) begin
                errors++;
                $display("FAIL run_tick[%0d] got %b exp %b", i, {state, lap, tick, clr}, exp_v);
            end
            checks++;
        end
    endtask

    task automatic test_pause();
        logic [4:0] exp_v;
        logic [4:0] seq [3];
        seq[0] = 5'b01010;
        seq[1] = 5'b01000;
        seq[2] = 5'b10000;
        btn_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if ({state, lap, tick, clr} !== seq[i]) begin
                errors++;
                $display("FAIL pause_enter[%0d] got %b exp %b", i, {state, lap, tick, clr}, seq[i]);
            end
            checks++;
        end
        btn_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if ({state, lap, tick, clr} !== 5'b10000) begin
                errors++;
                $display("FAIL pause_hold[%0d] got %b exp %b", i, {state, lap, tick, clr}, 5'b10000);
            end
            checks++;
        end
        btn_start = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            exp_v = (i == 3) ? 5'b01000 : 5'b10000;
            if ({state, lap, tick, clr} !== exp_v) begin
                errors++;
                $display("FAIL resume[%0d] got %b exp %b", i, {state, lap, tick, clr}, exp_v);
            end
            checks++;
        end
        btn_start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            exp_v = (i == 2) ? 5'b01010 : 5'b01000;
            if ({state, lap, tick, clr} !== exp_v) begin
                errors++;
                $display("FAIL resume_tick[%0d] got %b exp %b", i, {state, lap, tick, clr}, exp_v);
            end
            checks++;
        end
        btn_start = 1'b1;
        for (int i = 4; i <= 7; i++) begin
            step();
            case (i)
                6: exp_v = 5'b10010;
                7: exp_v = 5'b10000;
                default: exp_v = 5'b01000;
            endcase
            if ({state, lap, tick, clr} !== exp_v) begin
                errors++;
                $display("FAIL pause_on_wrap[%0d] got %b exp %b", i, {state, lap, tick, clr}, exp_v);
            end
            checks++;
        end
        btn_start = 1'b0;
    endtask

    task automatic test_clear();
        logic [4:0] exp_v;
        repeat (4) step();
        btn_lap = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            exp_v = (i == 3) ? 5'b00001 : 5'b10000;
            if ({state, lap, tick, clr} !== exp_v) begin
                errors++;
                $display("FAIL clear_pulse[%0d] got %b exp %b", i, {state, lap, tick, clr}, exp_v);
            end
            checks++;
        end
        btn_lap = 1'b0;
        step();
        if ({state, lap, tick, clr} !== 5'b00000) begin
            errors++;
            $display("FAIL clear_fall got %b exp %b", {state, lap, tick, clr}, 5'b00000);
        end
        checks++;
        btn_start = 1'b1;
        repeat (3) step();
        if ({state, lap, tick, clr} !== 5'b01000) begin
            errors++;
            $display("FAIL clear_restart got %b exp %b", {state, lap, tick, clr}, 5'b01000);
        end
        checks++;
        btn_start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            exp_v = (i == 4) ? 5'b01010 : 5'b01000;
            if ({state, lap, tick, clr} !== exp_v) begin
                errors++;
                $display("FAIL clear_first_tick[%0d] got %b exp %b", i, {state, lap, tick, clr}, exp_v);
            end
            checks++;
        end
    endtask

    task automatic test_lap();
        logic [4:0] exp_v;
        btn_lap = 1'b1;
        for (int i = 5; i <= 7; i++) begin
            step();
            exp_v = (i == 7) ? 5'b11100 : 5'b01000;
            if ({state, lap, tick, clr} !== exp_v) begin
                errors++;
                $display("FAIL lap_enter[%0d] got %b exp %b", i, {state, lap, tick, clr}, exp_v);
            end
            checks++;
        end
        btn_lap = 1'b0;
        for (int i = 8; i <= 12; i++) begin
            step();
            exp_v = (i == 8 || i == 12) ? 5'b11110 : 5'b11100;
            if ({state, lap, tick, clr} !== exp_v) begin
                errors++;
                $display("FAIL lap_tick[%0d] got %b exp %b", i, {state, lap, tick, clr}, exp_v);
            end
            checks++;
        end
        btn_lap = 1'b1;
        for (int i = 13; i <= 16; i++) begin
            step();
            case (i)
                15: exp_v = 5'b01000;
                16: exp_v = 5'b01010;
                default: exp_v = 5'b11100;
            endcase
            if ({state, lap, tick, clr} !== exp_v) begin
                errors++;
                $display("FAIL lap_release[%0d] got %b exp %b", i, {state, lap, tick, clr}, exp_v);
            end
            checks++;
        end
        btn_lap = 1'b0;
    endtask

    task automatic test_simul();
        logic [4:0] exp_v;
        repeat (4) step();
        btn_start = 1'b1;
        btn_lap = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            exp_v = (i == 3) ? 5'b10000 : 5'b01000;
            if ({state, lap, tick, clr} !== exp_v) begin
                errors++;
                $display("FAIL simul_press[%0d] got %b exp %b", i, {state, lap, tick, clr}, exp_v);
            end
            checks++;
        end
        for (int i = 0; i < 50; i++) begin
            step();
            if ({state, lap, tick, clr} !== 5'b10000) begin
                errors++;
                $display("FAIL simul_hold[%0d] got %b exp %b", i, {state, lap, tick, clr}, 5'b10000);
            end
            checks++;
        end
        btn_start = 1'b0;
        btn_lap = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [4:0] exp_v;
        repeat (4) step();
        btn_start = 1'b1;
        repeat (3) step();
        btn_start = 1'b0;
        btn_lap = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            case (i)
                1: exp_v = 5'b01010;
                2: exp_v = 5'b01000;
                default: exp_v = 5'b11100;
            endcase
            if ({state, lap, tick, clr} !== exp_v) begin
                errors++;
                $display("FAIL midreset_setup[%0d] got %b exp %b", i, {state, lap, tick, clr}, exp_v);
            end
            checks++;
        end
        btn_lap = 1'b0;
        #3 reset = 1'b0;
        #1;
        if ({state, lap, tick, clr} !== 5'b00000) begin
            errors++;
            $display("FAIL midreset_async got %b exp %b", {state, lap, tick, clr}, 5'b00000);
        end
        checks++;
        btn_start = 1'b1;
        step();
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            exp_v = (i == 3) ? 5'b01000 : 5'b00000;
            if ({state, lap, tick, clr} !== exp_v) begin
                errors++;
                $display("FAIL postreset_press[%0d] got %b exp %b", i, {state, lap, tick, clr}, exp_v);
            end
            checks++;
        end
        btn_start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            exp_v = (i % 4 == 0) ? 5'b01010 : 5'b01000;
            if ({state, lap, tick, clr} !== exp_v) begin
                errors++;
                $display("FAIL postreset_tick[%0d] got %b exp %b", i, {state, lap, tick, clr}, exp_v);
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_pause();
        test_clear();
        test_lap();
        test_simul();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
